// File: rtl/task1_a.sv
// Three-input ones counter (full adder) with a registered copy of the count
// and a saturating, sticky-flagged running accumulator of that count.
module task1_a #(
    parameter string IMPL  = "STRUCT",
    parameter int    ACC_W = 16
) (
    output logic [1:0]       y,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [1:0]       y_q,
    output logic [ACC_W-1:0] acc,
    output logic             acc_sat
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    generate
        if (IMPL == "STRUCT") begin : g_struct
            logic s;
            logic ab, ac, bc, cy;

            xor u_sum (s, a, b, c);
            and u_ab (ab, a, b);
            and u_ac (ac, a, c);
            and u_bc (bc, b, c);
            or  u_cy (cy, ab, ac, bc);

            assign y = {cy, s};
        end else begin : g_behav
            assign y = {1'b0, a} + {1'b0, b} + {1'b0, c};
        end
    endgenerate

    logic [1:0]       yreg_q, yreg_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [SUM_W-1:0] sum;

    // Sum is one bit wider than acc so the saturation test never sees a wrap.
    always_comb begin
        sum    = {1'b0, acc_q} + SUM_W'(y);
        yreg_d = en ? y : yreg_q;
        acc_d  = acc_q;
        sat_d  = sat_q;
        if (clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (en) begin
            if (sum >= {1'b0, ACC_MAX}) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yreg_q <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            yreg_q <= yreg_d;
            acc_q  <= acc_d;
            sat_q  <= sat_d;
        end
    end

    assign y_q     = yreg_q;
    assign acc     = acc_q;
    assign acc_sat = sat_q;

endmodule

// File: tb/tb_task1_a.sv
// Directed bench for task1_a: structural and behavioural builds at ACC_W=16
// plus a structural ACC_W=2 build, all sharing one set of inputs.
`timescale 1ns/1ps
module tb_task1_a;

    logic        clk;
    logic        rst_n;
    logic        a, b, c, en, clr;

    logic [1:0]  ys, yb, yw;
    logic [1:0]  yqs, yqb, yqw;
    logic [15:0] accs, accb;
    logic [1:0]  accw;
    logic        sats, satb, satw;

    int unsigned n_checks;
    int unsigned n_fails;

    task1_a #(.IMPL("STRUCT"), .ACC_W(16)) u_struct (
        .y(ys), .a(a), .b(b), .c(c), .clk(clk), .rst_n(rst_n), .en(en),
        .clr(clr), .y_q(yqs), .acc(accs), .acc_sat(sats)
    );

    task1_a #(.IMPL("BEHAV"), .ACC_W(16)) u_behav (
        .y(yb), .a(a), .b(b), .c(c), .clk(clk), .rst_n(rst_n), .en(en),
        .clr(clr), .y_q(yqb), .acc(accb), .acc_sat(satb)
    );

    task1_a #(.IMPL("STRUCT"), .ACC_W(2)) u_narrow (
        .y(yw), .a(a), .b(b), .c(c), .clk(clk), .rst_n(rst_n), .en(en),
        .clr(clr), .y_q(yqw), .acc(accw), .acc_sat(satw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abc(input logic [2:0] v);
        {a, b, c} = v;
    endtask

    logic [1:0] sweep_exp [8];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        sweep_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        set_abc(3'b000);
        #1;
        check("rst_yq",  32'(yqs),  32'd0);
        check("rst_acc", 32'(accs), 32'd0);
        check("rst_sat", 32'(sats), 32'd0);

        // Exhaustive sweep, 5 ps per step, while reset is held
        for (int unsigned i = 0; i < 8; i++) begin
            set_abc(3'(i));
            #0.005;
            check($sformatf("sweep_struct_%0d", i), 32'(ys), 32'(sweep_exp[i]));
            check($sformatf("sweep_behav_%0d", i),  32'(yb), 32'(sweep_exp[i]));
            check($sformatf("sweep_equal_%0d", i),  32'(ys), 32'(yb));
        end

        @(negedge clk);
        rst_n = 1'b1;

        set_abc(3'b111);
        en = 1'b1;
        tick();
        check("cap_yq",      32'(yqs),  32'd3);
        check("cap_acc",     32'(accs), 32'd3);
        check("narrow_acc1", 32'(accw), 32'd3);
        check("narrow_sat1", 32'(satw), 32'd1);

        en = 1'b0;
        set_abc(3'b000);
        tick();
        check("hold_yq", 32'(yqs), 32'd3);
        check("hold_y",  32'(ys),  32'd0);

        set_abc(3'b111);
        en = 1'b1;
        tick();
        check("narrow_acc2", 32'(accw), 32'd3);
        check("narrow_sat2", 32'(satw), 32'd1);
        check("acc_six",     32'(accs), 32'd6);

        set_abc(3'b000);
        tick();
        check("zero_add_acc", 32'(accs), 32'd6);
        check("zero_add_yq",  32'(yqs),  32'd0);

        en  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_acc",        32'(accs), 32'd0);
        check("narrow_clr_acc", 32'(accw), 32'd0);
        check("narrow_clr_sat", 32'(satw), 32'd0);

        set_abc(3'b011);
        en = 1'b1;
        for (int unsigned i = 0; i < 4; i++) tick();
        check("accum_acc",    32'(accs), 32'd8);
        check("accum_sat",    32'(sats), 32'd0);
        check("accum_behav",  32'(accb), 32'd8);
        check("narrow_acc3",  32'(accw), 32'd3);
        check("narrow_sat3",  32'(satw), 32'd1);

        en  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en  = 1'b1;
        set_abc(3'b101);
        tick();
        tick();
        set_abc(3'b001);
        tick();
        en = 1'b0;
        check("pre_rst_acc", 32'(accs), 32'd5);
        check("pre_rst_yq",  32'(yqs),  32'd1);

        // Reset asserted mid-cycle, well clear of any clock edge
        #2;
        rst_n = 1'b0;
        set_abc(3'b110);
        #1;
        check("async_acc", 32'(accs), 32'd0);
        check("async_yq",  32'(yqs),  32'd0);
        check("async_sat", 32'(satw), 32'd0);
        check("async_y",   32'(ys),   32'd2);

        @(negedge clk);
        rst_n = 1'b1;
        clr   = 1'b1;
        en    = 1'b1;
        set_abc(3'b101);
        tick();
        check("prio_acc",     32'(accs), 32'd0);
        check("prio_sat",     32'(sats), 32'd0);
        check("prio_yq",      32'(yqs),  32'd2);
        check("prio_narrow",  32'(accw), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/task1_a.md
TASK1_A -- requirements
Module: task1_a

Interface
REQ-001 The parameter IMPL SHALL default to "STRUCT" and SHALL select the y datapath: "STRUCT" means gate primitives only, "BEHAV" means a continuous arithmetic expression.
REQ-002 The parameter ACC_W SHALL default to 16 and SHALL set the accumulator width, with a legal range of 2 to 32.
REQ-003 clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-004 rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-005 y SHALL be an output, 2 bits wide: the combinational count of ones on a, b, c.
REQ-006 a, b and c SHALL each be an input, 1 bit wide, and are the data bits to be counted.
REQ-007 en SHALL be an input, 1 bit wide: the capture/accumulate enable.
REQ-008 clr SHALL be an input, 1 bit wide: the synchronous clear for the accumulator and its flag.
REQ-009 y_q SHALL be an output, 2 bits wide: the registered copy of y.
REQ-010 acc SHALL be an output, ACC_W bits wide: the running sum of y.
REQ-011 acc_sat SHALL be an output, 1 bit wide: the sticky accumulator saturation flag.
REQ-012 The positional order of the first four ports SHALL be y, a, b, c, followed by clk, rst_n, en, clr, y_q, acc, acc_sat.

Function
REQ-013 y SHALL equal a+b+c as an unsigned 2-bit value, purely combinational, with no clock or reset dependence.
REQ-014 y[0] SHALL equal a XOR b XOR c (the sum bit).
REQ-015 y[1] SHALL equal the majority function (a&b)|(a&c)|(b&c) (the carry bit).
REQ-016 y SHALL follow this truth table for abc -> y: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
REQ-017 The IMPL="STRUCT" and IMPL="BEHAV" builds SHALL produce bit-identical y for all 8 input combinations.
REQ-018 y SHALL settle within the same simulation timestep as an input change, with zero delay and no delta-cycle gating through registers.
REQ-019 On each rising clk edge with en=1, y_q SHALL load y; with en=0, y_q SHALL hold.
REQ-020 On each rising clk edge with en=1 and clr=0, acc SHALL load acc+y, saturating at 2^ACC_W-1.
REQ-021 acc SHALL never wrap.
REQ-022 acc_sat SHALL set on the edge where acc reaches or would exceed 2^ACC_W-1, and SHALL stay set until clr or reset.
REQ-023 On a rising edge with clr=1, acc and acc_sat SHALL go to 0 regardless of en.
REQ-024 clr SHALL take priority over accumulation on the same edge.
REQ-025 When clr=1 and en=1 on the same edge, y_q SHALL still load y.
REQ-026 When en=1 and y=0, acc SHALL remain unchanged and that edge SHALL count as a valid cycle.
REQ-027 X or Z on a, b or c SHALL propagate as X on y; registered outputs SHALL not be required to filter X.

Reset
REQ-028 rst_n=0 SHALL asynchronously force y_q=00, acc=0 and acc_sat=0, independent of clk.
REQ-029 y SHALL remain driven from a, b, c during reset.
REQ-030 Release of rst_n SHALL be synchronous-safe: the first update SHALL occur on the first rising clk edge with rst_n=1.
REQ-031 Assertion of rst_n mid-accumulation SHALL discard acc immediately, with no partial-cycle update.

Verification
REQ-032 Exhaustive sweep: drive abc through 000..111 in order, 5 ps apart -> y=00,01,01,10,01,10,10,11, checked for both IMPL builds, and the two builds SHALL be equal at each step.
REQ-033 Register capture: abc=111, en=1, one edge -> y_q=11; then en=0 and abc=000 -> y_q stays 11 while y=00.
REQ-034 Accumulate: after reset, abc=011 held with en=1 for 4 edges -> acc=8, acc_sat=0.
REQ-035 Saturation with ACC_W=2: abc=111 with en=1 -> acc=3 and acc_sat=1 after edge 1; acc stays 3 on further edges; clr=1 -> acc=0, acc_sat=0.
REQ-036 Async reset: with acc=5, drop rst_n between clock edges -> acc=0 and y_q=00 immediately, while y still tracks abc.
REQ-037 Priority: clr=1, en=1, abc=101 on one edge -> acc=0, acc_sat=0, y_q=10.
